// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the IF/MEM unified-memory port arbiter:
//   grant FSM state encoding and the width of the optional timeout counter.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_TO_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_MEM  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// arb_timeout_counter
//   Watchdog for a granted memory access. The count clears when an access
//   is granted and advances on every BUSY cycle without Mem_Ready.
//   Ports:
//     clk, reset  - clock, synchronous active-low reset
//     start       - access granted this cycle (clears the count)
//     busy        - arbiter is in a BUSY state
//     ready       - memory completes the access this cycle
//     expired     - combinational: abort the access this cycle
import mem_port_arbiter_pkg::*;

module arb_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic expired
);

  localparam logic [ARB_TO_W-1:0] TO_LAST = ARB_TO_W'(TIMEOUT - 1);

  logic [ARB_TO_W-1:0] count;

  // Abort in the BUSY cycle whose increment would make the count reach
  // TIMEOUT, so an access lasts at most TIMEOUT BUSY cycles.
  assign expired = busy & ~ready & (count == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (busy && !ready && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port variable-latency memory between IF (fetch) and
//   MEM (load/store). MEM has fixed priority. Three-state grant FSM, one
//   idle cycle between accesses, combinational per-stage stalls.
//   Optional feature macro: ARB_TIMEOUT_EN (abort after TIMEOUT BUSY cycles).
//   Ports:
//     clk, reset                     - clock, synchronous active-low reset
//     IF_Req, IF_Addr, IF_Flush      - fetch request, address, redirect
//     MEM_MemRead, MEM_MemWrite      - load / store request (both = store)
//     MEM_Addr, MEM_WData            - data address, store data
//     Mem_Ready, Mem_RData           - memory completion and read data
//     Mem_Req, Mem_Write             - registered access strobe / store flag
//     Mem_Addr, Mem_WData            - latched access address / store data
//     IF_Inst, IF_Valid              - fetched instruction, completion pulse
//     MEM_RData                      - load data, valid as MEM_Stall falls
//     IF_Stall, MEM_Stall            - per-stage stall requests
//     Mem_Timeout                    - sticky abort flag
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  input  logic        IF_Flush,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  input  logic        Mem_Ready,
  input  logic [31:0] Mem_RData,
  output logic        Mem_Req,
  output logic        Mem_Write,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [31:0] IF_Inst,
  output logic        IF_Valid,
  output logic [31:0] MEM_RData,
  output logic        IF_Stall,
  output logic        MEM_Stall,
  output logic        Mem_Timeout
);

  arb_state_t  state;
  logic        discard;
  logic        timed_out;
  logic        done;
  logic        mem_op;
  logic        if_go;
  logic        grant;
  logic        if_done;
  logic        mem_done;
  logic [31:0] rdata;

  assign mem_op   = MEM_MemRead | MEM_MemWrite;
  assign if_go    = IF_Req & ~IF_Flush;
  assign grant    = (state == ARB_IDLE) & (mem_op | if_go);
  assign done     = Mem_Ready | timed_out;
  assign if_done  = (state == ARB_IF)  & done;
  assign mem_done = (state == ARB_MEM) & done;

  // A timed-out access returns zero, which the pipeline executes as a nop.
  assign rdata     = timed_out ? '0 : Mem_RData;
  assign IF_Inst   = rdata;
  assign MEM_RData = rdata;

  // A flushed fetch still releases IF_Stall so the redirected PC loads,
  // but its data is never marked valid.
  assign IF_Valid  = if_done & ~discard & ~IF_Flush;
  assign IF_Stall  = IF_Req & ~if_done;
  assign MEM_Stall = mem_op & ~mem_done;

`ifdef ARB_TIMEOUT_EN
  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .start  (grant),
    .busy   (state != ARB_IDLE),
    .ready  (Mem_Ready),
    .expired(timed_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      Mem_Timeout <= 1'b0;
    end else if (timed_out) begin
      Mem_Timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT;
  assign timed_out          = 1'b0;
  assign Mem_Timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      Mem_Req   <= 1'b0;
      Mem_Write <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      discard   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (mem_op) begin
            state     <= ARB_MEM;
            Mem_Req   <= 1'b1;
            Mem_Write <= MEM_MemWrite;
            Mem_Addr  <= MEM_Addr;
            Mem_WData <= MEM_WData;
          end else if (if_go) begin
            state     <= ARB_IF;
            Mem_Req   <= 1'b1;
            Mem_Write <= 1'b0;
            Mem_Addr  <= IF_Addr;
            discard   <= 1'b0;
          end
        end
        ARB_IF: begin
          if (IF_Flush) begin
            discard <= 1'b1;
          end
          if (done) begin
            state   <= ARB_IDLE;
            Mem_Req <= 1'b0;
          end
        end
        ARB_MEM: begin
          if (done) begin
            state     <= ARB_IDLE;
            Mem_Req   <= 1'b0;
            Mem_Write <= 1'b0;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          Mem_Req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned TB_TO = 4;
  localparam logic [31:0] KEY   = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        IF_Req, IF_Flush, MEM_MemRead, MEM_MemWrite, Mem_Ready;
  logic [31:0] IF_Addr, MEM_Addr, MEM_WData, Mem_RData;
  logic        Mem_Req, Mem_Write, IF_Valid, IF_Stall, MEM_Stall, Mem_Timeout;
  logic [31:0] Mem_Addr, Mem_WData, IF_Inst, MEM_RData;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT(TB_TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .IF_Req     (IF_Req),
    .IF_Addr    (IF_Addr),
    .IF_Flush   (IF_Flush),
    .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite),
    .MEM_Addr   (MEM_Addr),
    .MEM_WData  (MEM_WData),
    .Mem_Ready  (Mem_Ready),
    .Mem_RData  (Mem_RData),
    .Mem_Req    (Mem_Req),
    .Mem_Write  (Mem_Write),
    .Mem_Addr   (Mem_Addr),
    .Mem_WData  (Mem_WData),
    .IF_Inst    (IF_Inst),
    .IF_Valid   (IF_Valid),
    .MEM_RData  (MEM_RData),
    .IF_Stall   (IF_Stall),
    .MEM_Stall  (MEM_Stall),
    .Mem_Timeout(Mem_Timeout)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned lat;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int unsigned stall;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        chk_data;
  } exp_t;

  typedef struct {
    logic        is_mem;
    logic [31:0] addr;
    logic [31:0] data;
  } alt_t;

  exp_t sbq[$];
  alt_t aq[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no completion within cycle budget", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One MEM-stage access against a memory of fixed latency.
  task automatic mem_txn(input vec_t v);
    exp_t        e;
    exp_t        g;
    int unsigned busy;
    int unsigned stall;
    bit          done;
    MEM_MemRead  = v.rd;
    MEM_MemWrite = v.wr;
    MEM_Addr     = v.addr;
    MEM_WData    = v.wdata;
    e.stall    = v.lat;
    e.data     = v.rdata;
    e.addr     = v.addr;
    e.wdata    = v.wdata;
    e.write    = v.wr;
    e.chk_data = v.rd & ~v.wr;
    sbq.push_back(e);
    busy  = 0;
    stall = 0;
    done  = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (Mem_Req) begin
        busy++;
        Mem_Ready = (busy == v.lat);
        Mem_RData = (busy == v.lat) ? v.rdata : 32'hBAD0_BAD0;
      end else begin
        // Ready while idle must be ignored by the arbiter.
        Mem_Ready = 1'b1;
        Mem_RData = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      if (MEM_Stall) begin
        stall++;
      end else begin
        done = 1;
        g = sbq.pop_front();
        check("mem_stall_cycles", stall, g.stall);
        if (g.chk_data) check("mem_rdata", MEM_RData, g.data);
        check("mem_addr", Mem_Addr, g.addr);
        check("mem_write", {31'b0, Mem_Write}, {31'b0, g.write});
        if (g.write) check("mem_wdata", Mem_WData, g.wdata);
        check("mem_req_busy", {31'b0, Mem_Req}, 32'd1);
      end
      tick();
    end
    if (!done) begin
      bound_fail("mem_txn");
      sbq.delete();
    end
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;
    Mem_Ready    = 1'b0;
    @(negedge clk);
    check("mem_req_after_done", {31'b0, Mem_Req}, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    alt_t        a;
    int unsigned busy, stall, cyc, req_hi;
    bit          done;
    logic        is_mem;
    logic [31:0] addr;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         3, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'h0000_0055, 1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0208, 32'hA5A5_A5A5, 2, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h0};

    reset = 1'b0; IF_Req = 1'b1; IF_Addr = '0; IF_Flush = 1'b0;
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_Addr = '0; MEM_WData = '0;
    Mem_Ready = 1'b0; Mem_RData = '0;

    // Reset state and stalls out of reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",   {31'b0, Mem_Req},     32'd0);
    check("rst_mem_write", {31'b0, Mem_Write},   32'd0);
    check("rst_mem_addr",  Mem_Addr,             32'd0);
    check("rst_mem_wdata", Mem_WData,            32'd0);
    check("rst_if_valid",  {31'b0, IF_Valid},    32'd0);
    check("rst_timeout",   {31'b0, Mem_Timeout}, 32'd0);
    check("rst_mem_stall", {31'b0, MEM_Stall},   32'd1);
    check("rst_if_stall",  {31'b0, IF_Stall},    32'd1);
    tick();
    IF_Req = 1'b0; MEM_MemRead = 1'b0; reset = 1'b1;
    tick();

    // Table-driven MEM accesses
    foreach (vecs[i]) mem_txn(vecs[i]);

    // Simultaneous IF and store: store first, then one idle, then fetch
    IF_Req = 1'b1; IF_Addr = 32'h0000_0040;
    MEM_MemWrite = 1'b1; MEM_Addr = 32'h0000_0200; MEM_WData = 32'h0000_0055;
    @(negedge clk);
    check("pri_if_stall_grant", {31'b0, IF_Stall}, 32'd1);
    tick();
    Mem_Ready = 1'b1; Mem_RData = 32'h0;
    @(negedge clk);
    check("pri_store_addr",  Mem_Addr,             32'h0000_0200);
    check("pri_store_write", {31'b0, Mem_Write},   32'd1);
    check("pri_mem_stall",   {31'b0, MEM_Stall},   32'd0);
    check("pri_if_stall",    {31'b0, IF_Stall},    32'd1);
    tick();
    MEM_MemWrite = 1'b0; Mem_Ready = 1'b0;
    @(negedge clk);
    check("pri_idle_gap",    {31'b0, Mem_Req},     32'd0);
    tick();
    Mem_Ready = 1'b1; Mem_RData = 32'h1234_ABCD;
    @(negedge clk);
    check("pri_fetch_addr",  Mem_Addr,             32'h0000_0040);
    check("pri_fetch_write", {31'b0, Mem_Write},   32'd0);
    check("pri_fetch_valid", {31'b0, IF_Valid},    32'd1);
    check("pri_fetch_inst",  IF_Inst,              32'h1234_ABCD);
    tick();
    IF_Req = 1'b0; Mem_Ready = 1'b0;
    tick();

    // Flush in the 2nd cycle of a 4-cycle fetch
    IF_Req = 1'b1; IF_Addr = 32'h0000_0080;
    tick();                                     // BUSY1
    @(negedge clk);
    check("fl_req_busy1", {31'b0, Mem_Req}, 32'd1);
    tick();                                     // BUSY2
    IF_Flush = 1'b1;
    tick();                                     // BUSY3
    IF_Flush = 1'b0; IF_Addr = 32'h0000_00C0;
    @(negedge clk);
    check("fl_req_held",  {31'b0, Mem_Req},  32'd1);
    check("fl_addr_held", Mem_Addr,          32'h0000_0080);
    check("fl_stall",     {31'b0, IF_Stall}, 32'd1);
    tick();                                     // BUSY4
    Mem_Ready = 1'b1; Mem_RData = 32'hAAAA_5555;
    @(negedge clk);
    check("fl_stall_drop", {31'b0, IF_Stall}, 32'd0);
    check("fl_no_valid",   {31'b0, IF_Valid}, 32'd0);
    tick();
    Mem_Ready = 1'b0;
    @(negedge clk);
    check("fl_idle_gap", {31'b0, Mem_Req}, 32'd0);
    tick();
    Mem_Ready = 1'b1; Mem_RData = 32'h0BBB_BBBB;
    @(negedge clk);
    check("fl_new_addr",  Mem_Addr,          32'h0000_00C0);
    check("fl_new_valid", {31'b0, IF_Valid}, 32'd1);
    check("fl_new_inst",  IF_Inst,           32'h0BBB_BBBB);
    tick();
    IF_Req = 1'b0; Mem_Ready = 1'b0;
    tick();

    // Flush while idle: no grant
    IF_Req = 1'b1; IF_Flush = 1'b1; IF_Addr = 32'h0000_00E0;
    tick();
    IF_Req = 1'b0; IF_Flush = 1'b0;
    @(negedge clk);
    check("fl_idle_no_grant", {31'b0, Mem_Req}, 32'd0);
    tick();

    // Reset in the middle of MEM_BUSY
    MEM_MemWrite = 1'b1; MEM_Addr = 32'h0000_0300; MEM_WData = 32'h0000_CAFE;
    tick();
    @(negedge clk);
    check("rb_busy_addr", Mem_Addr, 32'h0000_0300);
    tick();
    reset = 1'b0; MEM_MemWrite = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rb_mem_req",   {31'b0, Mem_Req},     32'd0);
    check("rb_mem_addr",  Mem_Addr,             32'd0);
    check("rb_mem_write", {31'b0, Mem_Write},   32'd0);
    check("rb_mem_wdata", Mem_WData,            32'd0);
    check("rb_timeout",   {31'b0, Mem_Timeout}, 32'd0);
    tick();

    // Zero-wait memory, alternating fetch/load with IF always requesting
    req_hi = 0;
    for (int k = 0; k < 8; k++) begin
      is_mem      = (k % 2) == 1;
      IF_Req      = 1'b1;
      IF_Addr     = 32'h0000_1000 + 32'(4 * k);
      MEM_MemRead = is_mem;
      MEM_Addr    = 32'h0000_2000 + 32'(4 * k);
      addr        = is_mem ? MEM_Addr : IF_Addr;
      aq.push_back('{is_mem, addr, addr ^ KEY});
      cyc  = 0;
      done = 0;
      for (int c = 0; c < 10 && !done; c++) begin
        Mem_Ready = Mem_Req;
        Mem_RData = Mem_Addr ^ KEY;
        if (Mem_Req) req_hi++;
        @(negedge clk);
        cyc++;
        if (is_mem ? !MEM_Stall : !IF_Stall) begin
          done = 1;
          a = aq.pop_front();
          check("alt_cycles", cyc, 32'd2);
          check("alt_addr", Mem_Addr, a.addr);
          if (a.is_mem) begin
            check("alt_mem_rdata", MEM_RData, a.data);
            check("alt_if_held", {31'b0, IF_Stall}, 32'd1);
          end else begin
            check("alt_if_inst", IF_Inst, a.data);
            check("alt_if_valid", {31'b0, IF_Valid}, 32'd1);
          end
        end
        tick();
      end
      if (!done) begin
        bound_fail("alt_op");
        aq.delete();
      end
    end
    IF_Req = 1'b0; MEM_MemRead = 1'b0; Mem_Ready = 1'b0;
    check("alt_busy_cycles", req_hi, 32'd8);
    tick();

`ifdef ARB_TIMEOUT_EN
    // Fetch with a memory that never answers
    IF_Req = 1'b1; IF_Addr = 32'h0000_3000;
    Mem_Ready = 1'b0; Mem_RData = 32'hFFFF_FFFF;
    busy = 0; stall = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (Mem_Req) busy++;
      @(negedge clk);
      if (IF_Stall) begin
        stall++;
      end else begin
        done = 1;
        check("to_busy_cycles", busy, TB_TO);
        check("to_stall_cycles", stall, TB_TO);
        check("to_inst_nop", IF_Inst, 32'h0);
        check("to_valid", {31'b0, IF_Valid}, 32'd1);
      end
      tick();
    end
    if (!done) bound_fail("to_abort");
    IF_Req = 1'b0;
    @(negedge clk);
    check("to_flag", {31'b0, Mem_Timeout}, 32'd1);
    check("to_req_drop", {31'b0, Mem_Req}, 32'd0);
    repeat (3) tick();
    @(negedge clk);
    check("to_flag_sticky", {31'b0, Mem_Timeout}, 32'd1);
    tick();
`else
    @(negedge clk);
    check("no_timeout_flag", {31'b0, Mem_Timeout}, 32'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
